cnt_sched: RTL and testbench

Round-robin scheduler that shares one W-bit interval counter between N_REQ requesters.
- Each requester asks for a timed interval of lim+1 enabled cycles.
- The block grants the counter to one requester, runs the count, and returns a one-cycle done pulse to the owner.
- Sits between client logic and the shared counter resource, as the sequencer/arbiter for that counter.

---
 rtl/cnt_sched.sv | 129 ++++++++++++
 tb/tb_cnt_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin owner of one shared W-bit interval counter across N_REQ requesters.
// Optional CNT_SCHED_BACK2BACK_EN: re-arbitrate in DONE so consecutive grants need no IDLE gap.
module cnt_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] lim,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [W-1:0]       cnt_val,
  output logic [N_REQ-1:0]   done,
  output logic               abort
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state, state_n;
  logic [N_REQ-1:0]            gnt_n;
  logic [IW-1:0]               owner, owner_n, last, last_n;
  logic [W-1:0]                lim_l, lim_n, cnt_n;
  logic                        abort_r, abort_n;
  logic [N_REQ-1:0][W-1:0]     lim_a;
  logic [IW-1:0]               arb_base, arb_start, arb_idx, idx;
  logic                        arb_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lim
    assign lim_a[i] = lim[i*W +: W];
  end

  // Search starts one past the most recently served index (owner in DONE).
  always_comb begin
    arb_base  = (state == DONE) ? owner : last;
    arb_start = (arb_base == IW'(N_REQ-1)) ? '0 : arb_base + IW'(1);
    arb_hit   = 1'b0;
    arb_idx   = '0;
    idx       = '0;
    // Walk from farthest to nearest so the nearest set bit wins.
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = IW'((int'(arb_start) + i) % N_REQ);
      if (req[idx]) begin
        arb_hit = 1'b1;
        arb_idx = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    last_n  = last;
    lim_n   = lim_l;
    cnt_n   = cnt_val;
    abort_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (arb_hit) begin
          state_n = RUN;
          gnt_n   = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
          owner_n = arb_idx;
          lim_n   = lim_a[arb_idx];
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_n = IDLE;
          gnt_n   = '0;
          abort_n = 1'b1;
          last_n  = owner;
          cnt_n   = '0;
        end else if (cnt_val == lim_l) begin
          state_n = DONE;
        end else if (en) begin
          cnt_n = cnt_val + W'(1);
        end
      end
      DONE: begin
        last_n  = owner;
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
`ifdef CNT_SCHED_BACK2BACK_EN
        if (arb_hit) begin
          state_n = RUN;
          gnt_n   = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
          owner_n = arb_idx;
          lim_n   = lim_a[arb_idx];
        end
`endif
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      last    <= IW'(N_REQ-1);
      lim_l   <= '0;
      cnt_val <= '0;
      abort_r <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      last    <= last_n;
      lim_l   <= lim_n;
      cnt_val <= cnt_n;
      abort_r <= abort_n;
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE) ? gnt : '0;
  assign abort = abort_r;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: reset, single interval, round-robin, enable stall, abort, mid-run reset.
module tb_cnt_sched;
  localparam int N_REQ = 4;
  localparam int W     = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] lim;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic [W-1:0]       cnt_val;
  logic [N_REQ-1:0]   done;
  logic               abort;

  int n_assert = 0;
  int n_fail   = 0;

  cnt_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .lim(lim),
    .gnt(gnt), .busy(busy), .cnt_val(cnt_val), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(gnt),     32'h0);
    chk({tag, "_cnt"},  32'(cnt_val), 32'h0);
    chk({tag, "_busy"}, 32'(busy),    32'h0);
    chk({tag, "_done"}, 32'(done),    32'h0);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    req = 4'b1111;
    lim = '0;

    // reset held with all requests pending
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rst_hold");
      chk("rst_abort", 32'(abort), 32'h0);
    end

    // release; round-robin with lim=0 everywhere
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt",  32'(gnt),  32'(4'b0001 << (k % 4)));
      chk("rr_busy", 32'(busy), 32'h1);
      chk("rr_done_run", 32'(done), 32'h0);
      tick();
      chk("rr_done", 32'(done), 32'(4'b0001 << (k % 4)));
      chk("rr_gnt_done", 32'(gnt), 32'(4'b0001 << (k % 4)));
      if (k == 4) req = 4'b0000;
`ifndef CNT_SCHED_BACK2BACK_EN
      tick();
      chk("rr_gap_gnt", 32'(gnt), 32'h0);
`endif
    end
    tick();
    chk_idle("rr_end");

    // single interval: requester 2, lim 5
    lim[2*W +: W] = 8'd5;
    req = 4'b0100;
    tick();
    for (int c = 0; c <= 5; c++) begin
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_cnt", 32'(cnt_val), 32'(c));
      chk("single_nodone", 32'(done), 32'h0);
      tick();
    end
    chk("single_done", 32'(done), 32'h4);
    chk("single_cnt_hold", 32'(cnt_val), 32'd5);
    req = 4'b0000;
    tick();
    chk_idle("single_end");

    // enable stall: requester 1, lim 3, en alternating
    lim[1*W +: W] = 8'd3;
    req = 4'b0010;
    tick();
    chk("stall_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 6; i++) begin
      en = (i % 2 == 0);
      chk("stall_cnt", 32'(cnt_val), 32'((i + 1) / 2));
      chk("stall_nodone", 32'(done), 32'h0);
      tick();
    end
    chk("stall_done", 32'(done), 32'h2);
    chk("stall_cnt_end", 32'(cnt_val), 32'd3);
    en  = 1'b1;
    req = 4'b0000;
    tick();
    chk_idle("stall_end");

    // abort: requester 3, lim 200, dropped at cnt 10
    lim[3*W +: W] = 8'd200;
    lim[0*W +: W] = 8'd0;
    req = 4'b1000;
    tick();
    chk("abort_gnt", 32'(gnt), 32'h8);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_cnt10", 32'(cnt_val), 32'd10);
    req = 4'b0000;
    tick();
    chk("abort_pulse", 32'(abort), 32'h1);
    chk_idle("abort_idle");
    // pointer must now sit at 3, so requester 0 beats 1 and 2
    req = 4'b0111;
    tick();
    chk("abort_next_gnt", 32'(gnt), 32'h1);
    chk("abort_one_cycle", 32'(abort), 32'h0);
    req = 4'b0000;
    tick();
    chk("abort2_pulse", 32'(abort), 32'h1);
    chk("abort2_gnt", 32'(gnt), 32'h0);

    // mid-run reset at cnt 100
    lim = {N_REQ{8'd255}};
    req = 4'b0010;
    tick();
    chk("mrst_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 100; i++) tick();
    chk("mrst_cnt100", 32'(cnt_val), 32'd100);
    rst = 1'b0;
    tick();
    chk_idle("mrst_reset");
    chk("mrst_abort", 32'(abort), 32'h0);
    lim[0*W +: W] = 8'd2;
    rst = 1'b1;
    req = 4'b1111;
    tick();
    chk("mrst_regnt", 32'(gnt), 32'h1);

    // owner drops req exactly at terminal count: abort wins
    tick();
    tick();
    chk("prec_cnt", 32'(cnt_val), 32'd2);
    req = 4'b0000;
    tick();
    chk("prec_abort", 32'(abort), 32'h1);
    chk("prec_nodone", 32'(done), 32'h0);
    chk("prec_gnt", 32'(gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
